// File: rtl/pipe_stage_hs.sv
// Chain of STAGES handshake registers, each a main register plus one skid slot,
// so in_ready is registered and back-pressure moves one stage per cycle.
module pipe_stage_hs #(
  parameter int WIDTH     = 64,
  parameter int STAGES    = 1,
  parameter int CNT_WIDTH = 16,
  parameter int OCC_WIDTH = $clog2(2*STAGES+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [OCC_WIDTH-1:0] occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  // Handshake: a word moves across a boundary on a rising edge exactly when
  // valid and ready are both 1 in the preceding cycle; a valid, once raised,
  // holds its data until that transfer (or a flush/reset) happens.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd3
  } stageStateT;

  logic [STAGES-1:0] mValid, sValid;
  logic [WIDTH-1:0]  mData [STAGES];
  logic [WIDTH-1:0]  sData [STAGES];

  logic [STAGES-1:0] mValidNext, sValidNext;
  logic [WIDTH-1:0]  mDataNext [STAGES];
  logic [WIDTH-1:0]  sDataNext [STAGES];
  logic [OCC_WIDTH-1:0] occNext;

  logic [STAGES-1:0] upValid, downReady, accept, drain;
  logic [WIDTH-1:0]  upData [STAGES];
  stageStateT        stageState [STAGES];

  always_comb begin
    upValid[0] = in_valid;
    upData[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      upValid[k] = mValid[k-1];
      upData[k]  = mData[k-1];
    end
    downReady[STAGES-1] = out_ready;
    for (int k = 0; k < STAGES-1; k++) begin
      downReady[k] = ~sValid[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      accept[k] = upValid[k] & ~sValid[k];
      drain[k]  = mValid[k] & downReady[k];
      if (sValid[k])      stageState[k] = FULL;
      else if (mValid[k]) stageState[k] = BUSY;
      else                stageState[k] = EMPTY;
    end
  end

  always_comb begin
    mValidNext = mValid;
    sValidNext = sValid;
    for (int k = 0; k < STAGES; k++) begin
      mDataNext[k] = mData[k];
      sDataNext[k] = sData[k];
    end
    // Flush drops only the valid bits; payload registers keep stale data.
    if (flush) begin
      mValidNext = '0;
      sValidNext = '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        case (stageState[k])
          EMPTY: begin
            if (accept[k]) begin
              mValidNext[k] = 1'b1;
              mDataNext[k]  = upData[k];
            end
          end
          BUSY: begin
            if (accept[k] && drain[k]) begin
              mDataNext[k] = upData[k];
            end else if (accept[k]) begin
              sValidNext[k] = 1'b1;
              sDataNext[k]  = upData[k];
            end else if (drain[k]) begin
              mValidNext[k] = 1'b0;
            end
          end
          FULL: begin
            if (drain[k]) begin
              mDataNext[k]  = sData[k];
              sValidNext[k] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    occNext = '0;
    for (int k = 0; k < STAGES; k++) begin
      occNext = occNext + OCC_WIDTH'(mValidNext[k]) + OCC_WIDTH'(sValidNext[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mValid    <= '0;
      sValid    <= '0;
      occupancy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        mData[k] <= '0;
        sData[k] <= '0;
      end
    end else begin
      mValid    <= mValidNext;
      sValid    <= sValidNext;
      occupancy <= occNext;
      for (int k = 0; k < STAGES; k++) begin
        mData[k] <= mDataNext[k];
        sData[k] <= sDataNext[k];
      end
    end
  end

  // Stall telemetry survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (mValid[STAGES-1] && !out_ready && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  assign in_ready  = ~sValid[0];
  assign out_valid = mValid[STAGES-1];
  assign out_data  = mData[STAGES-1];

endmodule
